// File: rtl/uart_line_pkg.sv
// -----------------------------------------------------------------------------
// uart_line_pkg
// Shared definitions for the UART line-echo block:
//   - state_t  : FSM state encoding used by uart_line_echo
//   - CHAR_*   : control characters recognised on the receive side
//   - to_upper : ASCII lower-to-upper case mapping, used only when the
//                LINE_ECHO_UPCASE_EN macro is defined at build time
// -----------------------------------------------------------------------------
package uart_line_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      SETTLE,
      CLASSIFY,
      ECHO,
      SEND_CR,
      SEND_LF,
      GAP
   } state_t;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_BS = 8'h08;

   // 'a'..'z' map to 'A'..'Z'; every other byte passes through unchanged.
   function automatic logic [7:0] to_upper(input logic [7:0] i_char);
      if ((i_char >= 8'h61) && (i_char <= 8'h7A)) begin
         return i_char - 8'h20;
      end
      return i_char;
   endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// -----------------------------------------------------------------------------
// line_buffer_ram
// DEPTH x 8 storage for one text line.
//   clk     : system clock
//   i_we    : write enable (synchronous write)
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address (asynchronous read)
//   o_rdata : read data, combinationally follows i_raddr
// -----------------------------------------------------------------------------
module line_buffer_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   // NOTE: storage arrays carry no reset; line_count gates which entries are
   // ever read, so stale contents are harmless and the array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_line_echo.sv
// -----------------------------------------------------------------------------
// uart_line_echo
// Collects characters from a UART receive FIFO into a line buffer; on CR the
// stored line is written to the transmit FIFO followed by CR LF. BS deletes
// the last stored character. Characters beyond LINE_DEPTH are dropped and
// flagged with a sticky overflow bit that clears after the line is echoed.
//
// Build option: define LINE_ECHO_UPCASE_EN to store 'a'..'z' as 'A'..'Z'.
//
// Ports:
//   clk              : system clock
//   reset            : synchronous, active-low reset
//   rx_data_in       : head byte of the receive FIFO
//   rx_data_present  : receive FIFO is non-empty
//   read_rx_data_ack : one-cycle pop of the receive FIFO
//   tx_data_out      : registered byte to transmit, held between writes
//   write_tx_data    : one-cycle push into the transmit FIFO
//   tx_buffer_full   : transmit FIFO is full
//   line_count       : number of characters currently stored
//   overflow         : sticky, a character of the current line was dropped
//   busy             : FSM is outside IDLE
// -----------------------------------------------------------------------------
module uart_line_echo
   import uart_line_pkg::*;
#(
   parameter int LINE_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  rx_data_in,
   input  logic                        rx_data_present,
   output logic                        read_rx_data_ack,
   output logic [7:0]                  tx_data_out,
   output logic                        write_tx_data,
   input  logic                        tx_buffer_full,
   output logic [$clog2(LINE_DEPTH):0] line_count,
   output logic                        overflow,
   output logic                        busy
);

   localparam int AW = $clog2(LINE_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(LINE_DEPTH);

   // Registered state
   state_t        r_state;
   state_t        r_gap_ret;     // where GAP goes once the spacing cycle is over
   logic [7:0]    r_byte;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_index;
   logic          r_overflow;
   logic [7:0]    r_tx_data;
   logic          r_write;

   // Next-state and datapath control
   state_t        w_next_state;
   state_t        w_next_gap_ret;
   logic          w_ram_we;
   logic          w_count_inc;
   logic          w_count_dec;
   logic          w_set_ovf;
   logic          w_idx_clr;
   logic          w_idx_inc;
   logic          w_clear_line;
   logic          w_load_tx;
   logic [7:0]    w_tx_byte;
   logic [7:0]    w_rd_data;
   logic [7:0]    w_store_byte;

`ifdef LINE_ECHO_UPCASE_EN
   assign w_store_byte = to_upper(r_byte);
`else
   assign w_store_byte = r_byte;
`endif

   line_buffer_ram #(
      .DEPTH (LINE_DEPTH),
      .AW    (AW)
   ) u_line_buffer_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_waddr (r_count[AW-1:0]),
      .i_wdata (w_store_byte),
      .i_raddr (r_index[AW-1:0]),
      .o_rdata (w_rd_data)
   );

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every signal gets its default before the case so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_next_state   = r_state;
      w_next_gap_ret = r_gap_ret;
      w_ram_we       = 1'b0;
      w_count_inc    = 1'b0;
      w_count_dec    = 1'b0;
      w_set_ovf      = 1'b0;
      w_idx_clr      = 1'b0;
      w_idx_inc      = 1'b0;
      w_clear_line   = 1'b0;
      w_load_tx      = 1'b0;
      w_tx_byte      = 8'h00;

      unique case (r_state)
         IDLE: begin
            if (rx_data_present) begin
               w_next_state = POP;
            end
         end

         POP: begin
            w_next_state = SETTLE;
         end

         // Gives the receive FIFO one cycle to update rx_data_present.
         SETTLE: begin
            w_next_state = CLASSIFY;
         end

         CLASSIFY: begin
            if (r_byte == CHAR_CR) begin
               w_idx_clr    = 1'b1;
               w_next_state = ECHO;
            end else if (r_byte == CHAR_BS) begin
               w_count_dec  = (r_count != '0);
               w_next_state = IDLE;
            end else if (r_count < DEPTH_C) begin
               w_ram_we     = 1'b1;
               w_count_inc  = 1'b1;
               w_next_state = IDLE;
            end else begin
               w_set_ovf    = 1'b1;
               w_next_state = IDLE;
            end
         end

         ECHO: begin
            if (r_index == r_count) begin
               w_next_state = SEND_CR;
            end else if (!tx_buffer_full) begin
               w_load_tx      = 1'b1;
               w_tx_byte      = w_rd_data;
               w_idx_inc      = 1'b1;
               w_next_gap_ret = ECHO;
               w_next_state   = GAP;
            end
         end

         SEND_CR: begin
            if (!tx_buffer_full) begin
               w_load_tx      = 1'b1;
               w_tx_byte      = CHAR_CR;
               w_next_gap_ret = SEND_LF;
               w_next_state   = GAP;
            end
         end

         SEND_LF: begin
            if (!tx_buffer_full) begin
               w_load_tx      = 1'b1;
               w_tx_byte      = CHAR_LF;
               w_next_gap_ret = IDLE;
               w_next_state   = GAP;
            end
         end

         // The write registered on entry is visible during this cycle; the
         // LF gap ends the line and releases the buffer.
         GAP: begin
            w_next_state = r_gap_ret;
            w_clear_line = (r_gap_ret == IDLE);
         end

         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_gap_ret  <= IDLE;
         r_byte     <= 8'h00;
         r_count    <= '0;
         r_index    <= '0;
         r_overflow <= 1'b0;
         r_tx_data  <= 8'h00;
         r_write    <= 1'b0;
      end else begin
         r_gap_ret <= w_next_gap_ret;

         if (r_state == POP) begin
            r_byte <= rx_data_in;
         end

         if (w_clear_line) begin
            r_count <= '0;
         end else if (w_count_inc) begin
            r_count <= r_count + CW'(1);
         end else if (w_count_dec) begin
            r_count <= r_count - CW'(1);
         end

         if (w_clear_line || w_idx_clr) begin
            r_index <= '0;
         end else if (w_idx_inc) begin
            r_index <= r_index + CW'(1);
         end

         if (w_clear_line) begin
            r_overflow <= 1'b0;
         end else if (w_set_ovf) begin
            r_overflow <= 1'b1;
         end

         // Data and strobe are registered together so the byte is valid in
         // the same cycle the push is asserted.
         r_write <= w_load_tx;
         if (w_load_tx) begin
            r_tx_data <= w_tx_byte;
         end
      end
   end

   assign read_rx_data_ack = (r_state == POP);
   assign write_tx_data    = r_write;
   assign tx_data_out      = r_tx_data;
   assign line_count       = r_count;
   assign overflow         = r_overflow;
   assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_uart_line_echo.sv
// -----------------------------------------------------------------------------
// tb_uart_line_echo
// Self-checking bench for uart_line_echo. The receive FIFO is a byte queue,
// the transmit side is captured into a queue, and a line-level reference
// model (a queue of stored characters) predicts the echoed stream,
// line_count and overflow. Honours LINE_ECHO_UPCASE_EN when defined.
// -----------------------------------------------------------------------------
module tb_uart_line_echo;

   localparam int LINE_DEPTH = 16;
   localparam int CW = $clog2(LINE_DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic [7:0]    rx_data_in;
   logic          rx_data_present;
   logic          read_rx_data_ack;
   logic [7:0]    tx_data_out;
   logic          write_tx_data;
   logic          tx_buffer_full;
   logic [CW-1:0] line_count;
   logic          overflow;
   logic          busy;

   logic          force_full;
   logic          rand_en;
   logic          rand_bit;

   assign tx_buffer_full = force_full | (rand_en & rand_bit);

   uart_line_echo #(
      .LINE_DEPTH (LINE_DEPTH)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .rx_data_in       (rx_data_in),
      .rx_data_present  (rx_data_present),
      .read_rx_data_ack (read_rx_data_ack),
      .tx_data_out      (tx_data_out),
      .write_tx_data    (write_tx_data),
      .tx_buffer_full   (tx_buffer_full),
      .line_count       (line_count),
      .overflow         (overflow),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------------------------------------------------------- queues
   logic [7:0] rx_q[$];      // receive FIFO contents
   logic [7:0] tx_obs[$];    // bytes pushed by the DUT
   logic [7:0] exp_tx[$];    // bytes the model expects
   logic [7:0] m_line[$];    // model's stored line
   logic       m_ovf;
   int         ack_cyc[$];   // cycle numbers of each receive pop

   // ------------------------------------------------------- reference model
   function automatic logic [7:0] model_store(input logic [7:0] b);
`ifdef LINE_ECHO_UPCASE_EN
      if (b >= "a" && b <= "z") return b - ("a" - "A");
`endif
      return b;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'h0D) begin
         foreach (m_line[i]) exp_tx.push_back(m_line[i]);
         exp_tx.push_back(8'h0D);
         exp_tx.push_back(8'h0A);
         m_line.delete();
         m_ovf = 1'b0;
      end else if (b == 8'h08) begin
         if (m_line.size() > 0) void'(m_line.pop_back());
      end else if (m_line.size() < LINE_DEPTH) begin
         m_line.push_back(model_store(b));
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_q.push_back(b);
      model_byte(b);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   // --------------------------------------------- FIFO emulation + monitor
   int   cyc = 0;
   logic prev_wr = 1'b0;
   logic prev_ack = 1'b0;
   logic pop_req;
   logic [7:0] last_tx;
   logic last_tx_valid = 1'b0;

   initial begin
      rx_data_present = 1'b0;
      rx_data_in      = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            last_tx_valid = 1'b0;
         end else begin
            if (write_tx_data) begin
               tx_obs.push_back(tx_data_out);
               check("wr_vs_ack", read_rx_data_ack, 0);
               check("wr_back_to_back", prev_wr, 0);
               last_tx = tx_data_out;
               last_tx_valid = 1'b1;
            end else if (last_tx_valid) begin
               check("tx_hold", tx_data_out, last_tx);
            end
            if (read_rx_data_ack) begin
               ack_cyc.push_back(cyc);
               check("ack_back_to_back", prev_ack, 0);
               check("ack_with_data", rx_data_present, 1);
            end
         end
         prev_wr  = write_tx_data;
         prev_ack = read_rx_data_ack;
         pop_req  = read_rx_data_ack;
         @(posedge clk);
         #1;
         if (pop_req && rx_q.size() > 0) void'(rx_q.pop_front());
         rx_data_present = (rx_q.size() > 0);
         rx_data_in      = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      end
   end

   initial begin
      rand_bit = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rand_bit = ($urandom_range(0, 3) == 0);
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic wait_idle();
      int n = 0;
      int quiet = 0;
      while (quiet < 3 && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
         if (rx_q.size() == 0 && !busy) quiet++;
         else quiet = 0;
      end
      check("idle_reached", (quiet >= 3), 1);
   endtask

   task automatic check_state(input string tag);
      check($sformatf("%s_count", tag), line_count, m_line.size());
      check($sformatf("%s_ovf", tag), overflow, m_ovf);
   endtask

   task automatic compare_stream(input string tag);
      int n;
      check($sformatf("%s_len", tag), tx_obs.size(), exp_tx.size());
      n = (tx_obs.size() < exp_tx.size()) ? tx_obs.size() : exp_tx.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_byte%0d", tag, i), tx_obs[i], exp_tx[i]);
      end
      tx_obs.delete();
      exp_tx.delete();
   endtask

   task automatic wait_writes(input int n_wr);
      int n = 0;
      while (tx_obs.size() < n_wr && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("writes_reached", (tx_obs.size() >= n_wr), 1);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int nw;
      reset      = 1'b0;
      force_full = 1'b0;
      rand_en    = 1'b0;
      m_ovf      = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack", read_rx_data_ack, 0);
      check("rst_wr", write_tx_data, 0);
      check("rst_txd", tx_data_out, 0);
      check("rst_count", line_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Basic line
      send_str("abc");
      send_byte(8'h0D);
      wait_idle();
      check_state("abc");
      compare_stream("abc");

      // Backspace inside a line, then a lone backspace at count 0
      send_str("ab");
      send_byte(8'h08);
      send_str("c");
      send_byte(8'h0D);
      wait_idle();
      compare_stream("bs_line");
      send_byte(8'h08);
      wait_idle();
      check_state("bs_empty");

      // Empty line echoes only CR LF
      send_byte(8'h0D);
      wait_idle();
      compare_stream("empty_line");

      // Back-to-back receive: pops exactly 4 cycles apart
      ack_cyc.delete();
      send_str("wxyz");
      wait_idle();
      check("b2b_pops", ack_cyc.size(), 4);
      for (int i = 1; i < ack_cyc.size(); i++) begin
         check($sformatf("b2b_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
      end
      check_state("b2b");
      send_byte(8'h0D);
      wait_idle();
      compare_stream("b2b_echo");

      // Overflow: 20 characters into a 16-deep line
      for (int i = 0; i < 20; i++) begin
         send_byte(8'h41 + 8'(i));
         wait_idle();
         check_state($sformatf("ovf_char%0d", i + 1));
      end
      send_byte(8'h0D);
      wait_idle();
      check_state("ovf_cleared");
      compare_stream("ovf_echo");

      // Transmit FIFO full for 50 cycles mid-echo
      send_str("0123456789");
      send_byte(8'h0D);
      wait_writes(2);
      @(posedge clk);
      #1;
      force_full = 1'b1;
      nw = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (write_tx_data) nw++;
      end
      check("stall_writes", nw, 0);
      force_full = 1'b0;
      wait_idle();
      compare_stream("stall_echo");

      // Reset during the third echoed byte aborts the echo
      send_str("abcdef");
      send_byte(8'h0D);
      wait_writes(3);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_abort_writes", tx_obs.size(), 3);
      while (exp_tx.size() > 3) void'(exp_tx.pop_back());
      compare_stream("rst_prefix");
      m_line.delete();
      m_ovf = 1'b0;
      check("rst2_count", line_count, 0);
      check("rst2_ovf", overflow, 0);
      check("rst2_busy", busy, 0);
      check("rst2_txd", tx_data_out, 0);
      send_str("x");
      send_byte(8'h0D);
      wait_idle();
      compare_stream("post_rst");

      // Randomised lines with random transmit back-pressure
      rand_en = 1'b1;
      for (int ln = 0; ln < 25; ln++) begin
         int len;
         bit step;
         len  = $urandom_range(0, 22);
         step = $urandom_range(0, 1);
         for (int k = 0; k < len; k++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0)      send_byte(8'h08);
            else if (r == 1) send_byte(8'h0A);
            else             send_byte(8'($urandom_range(8'h20, 8'h7E)));
            if (step) begin
               wait_idle();
               check_state($sformatf("rnd%0d_c%0d", ln, k));
            end
         end
         wait_idle();
         check_state($sformatf("rnd%0d_pre", ln));
         send_byte(8'h0D);
         wait_idle();
         check_state($sformatf("rnd%0d_post", ln));
         compare_stream($sformatf("rnd%0d", ln));
      end
      rand_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
